cache_instr_aligner: RTL and testbench

//  Sequential fetch aligner between core and I-cache for mixed RVC/RV32 streams.
//  Per request: looks up the line holding PC, extracts a 16- or 32-bit instruction from any halfword.
//  A 32-bit instruction that straddles a line boundary triggers a lookup of the next line, plus a refill on miss.
//  The aligner holds the low half meanwhile and returns one aligned instruction per request.

---
 rtl/cache_instr_aligner_pkg.sv | 41 ++++
 rtl/cache_instr_aligner_extract.sv | 44 ++++
 rtl/cache_instr_aligner.sv | 196 +++++++++++++++++++
 tb/tb_cache_instr_aligner.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_instr_aligner_pkg.sv
// ---------------------------------------------------------------------------
// cache_instr_aligner_pkg
//   Shared state encoding, RVC decode constant and line-geometry helpers for
//   the instruction fetch aligner.
//   Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package cache_instr_aligner_pkg;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LOOKUP     = 3'd1,
    S_LOOKUP_NXT = 3'd2,
    S_REFILL_CUR = 3'd3,
    S_REFILL_NXT = 3'd4,
    S_RESP       = 3'd5
  } state_e;

  // Both low bits set marks a 32-bit encoding; anything else is compressed.
  localparam logic [1:0] RVC_MASK = 2'b11;

  function automatic logic is_rvc(input logic [15:0] hw);
    return (hw[1:0] & RVC_MASK) != RVC_MASK;
  endfunction

  function automatic int block_bytes(input int block_size);
    return block_size / 8;
  endfunction

  function automatic int hw_cnt(input int block_size);
    return block_size / 16;
  endfunction

  function automatic int off_w(input int block_size);
    return $clog2(block_size / 8);
  endfunction

endpackage

`default_nettype wire

// File: rtl/cache_instr_aligner_extract.sv
// ---------------------------------------------------------------------------
// cache_instr_aligner_extract
//   Combinational halfword selector: returns the halfword at an index, the
//   following halfword (zero when none exists in the line) and a flag marking
//   the last halfword of the line.
//   Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cache_instr_aligner_extract
  import cache_instr_aligner_pkg::*;
#(
  parameter int BLOCK_SIZE = 128,
  parameter int IDX_W      = 3
) (
  input  logic [BLOCK_SIZE-1:0] block,
  input  logic [IDX_W-1:0]      idx,
  output logic [15:0]           hw_lo,
  output logic [15:0]           hw_hi,
  output logic                  last
);

  localparam int HW_CNT = hw_cnt(BLOCK_SIZE);
  localparam logic [IDX_W-1:0] LAST_HW = IDX_W'(HW_CNT - 1);

  logic [15:0] hws [HW_CNT];

  for (genvar g = 0; g < HW_CNT; g++) begin : g_hw
    assign hws[g] = block[g*16 +: 16];
  end

  // Select the addressed halfword and its successor within the same line.
  always_comb begin
    hw_lo = hws[idx];
    hw_hi = '0;
    last  = (idx == LAST_HW);
    if (!last) begin
      hw_hi = hws[idx + 1'b1];
    end
  end

endmodule

`default_nettype wire

// File: rtl/cache_instr_aligner.sv
// ---------------------------------------------------------------------------
// cache_instr_aligner
//   Sequential fetch aligner between core and I-cache for mixed RVC/RV32
//   streams. Looks up the line holding the PC, extracts a 16- or 32-bit
//   instruction, and for 32-bit instructions straddling a line boundary
//   fetches (and if needed refills) the next line while holding the low half.
//   Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cache_instr_aligner
  import cache_instr_aligner_pkg::*;
#(
  parameter int BLOCK_SIZE = 128,
  parameter int ADDR_W     = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  core_req_i,
  input  logic [ADDR_W-1:0]     core_pc_i,
  output logic                  core_gnt_o,
  output logic                  core_valid_o,
  input  logic                  core_ready_i,
  output logic [31:0]           core_instr_o,
  output logic                  core_rvc_o,
  output logic                  cache_rd_o,
  output logic [ADDR_W-1:0]     cache_addr_o,
  input  logic                  cache_hit_i,
  input  logic [BLOCK_SIZE-1:0] cache_block_i,
  output logic                  refill_req_o,
  output logic [ADDR_W-1:0]     refill_addr_o,
  input  logic                  refill_done_i
);

  localparam int BLOCK_BYTES = block_bytes(BLOCK_SIZE);
  localparam int OFF_W       = off_w(BLOCK_SIZE);
  localparam int IDX_W       = OFF_W - 1;

  state_e              state;
  logic [ADDR_W-1:1]   pc_q;
  logic [15:0]         hold_q;
  logic [ADDR_W-1:0]   line_q;
  logic                pend_flush;
  logic                gnt_q;
  logic                rd_q;
  logic                refill_q;
  logic                valid_q;
  logic [31:0]         instr_q;
  logic                rvc_q;

  logic [15:0]         hw_lo;
  logic [15:0]         hw_hi;
  logic                hw_last;
  logic [ADDR_W-1:0]   line_cur;
  logic [ADDR_W-1:0]   line_nxt;
  logic [ADDR_W-1:0]   line_req;
  logic                pc_lsb_unused;

  // Halfword address bit 0 carries no information for the aligner.
  assign pc_lsb_unused = core_pc_i[0];

  assign line_cur = {pc_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign line_nxt = line_cur + ADDR_W'(BLOCK_BYTES);
  assign line_req = {core_pc_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  cache_instr_aligner_extract #(
    .BLOCK_SIZE (BLOCK_SIZE),
    .IDX_W      (IDX_W)
  ) u_extract (
    .block (cache_block_i),
    .idx   (pc_q[OFF_W-1:1]),
    .hw_lo (hw_lo),
    .hw_hi (hw_hi),
    .last  (hw_last)
  );

  // Grant is registered so it stays low out of reset, but a flush masks it
  // within the same cycle so flush always wins over a new request.
  assign core_gnt_o    = gnt_q & ~flush_i;
  assign core_valid_o  = valid_q;
  assign core_instr_o  = instr_q;
  assign core_rvc_o    = rvc_q;
  assign cache_rd_o    = rd_q;
  assign cache_addr_o  = line_q;
  assign refill_req_o  = refill_q;
  assign refill_addr_o = line_q;

  // Fetch FSM with registered outputs; a refill is never abandoned midway,
  // a flush during refill is remembered and honoured once the refill ends.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= S_IDLE;
      pc_q       <= '0;
      hold_q     <= '0;
      line_q     <= '0;
      pend_flush <= 1'b0;
      gnt_q      <= 1'b0;
      rd_q       <= 1'b0;
      refill_q   <= 1'b0;
      valid_q    <= 1'b0;
      instr_q    <= '0;
      rvc_q      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          gnt_q <= 1'b1;
          if (core_req_i && core_gnt_o) begin
            pc_q   <= core_pc_i[ADDR_W-1:1];
            line_q <= line_req;
            gnt_q  <= 1'b0;
            rd_q   <= 1'b1;
            state  <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (flush_i) begin
            rd_q  <= 1'b0;
            gnt_q <= 1'b1;
            state <= S_IDLE;
          end else if (!cache_hit_i) begin
            rd_q     <= 1'b0;
            refill_q <= 1'b1;
            state    <= S_REFILL_CUR;
          end else if (is_rvc(hw_lo)) begin
            rd_q    <= 1'b0;
            valid_q <= 1'b1;
            instr_q <= {16'h0000, hw_lo};
            rvc_q   <= 1'b1;
            state   <= S_RESP;
          end else if (!hw_last) begin
            rd_q    <= 1'b0;
            valid_q <= 1'b1;
            instr_q <= {hw_hi, hw_lo};
            rvc_q   <= 1'b0;
            state   <= S_RESP;
          end else begin
            hold_q <= hw_lo;
            line_q <= line_nxt;
            state  <= S_LOOKUP_NXT;
          end
        end
        S_LOOKUP_NXT: begin
          rd_q <= 1'b0;
          if (flush_i) begin
            gnt_q <= 1'b1;
            state <= S_IDLE;
          end else if (cache_hit_i) begin
            valid_q <= 1'b1;
            instr_q <= {cache_block_i[15:0], hold_q};
            rvc_q   <= 1'b0;
            state   <= S_RESP;
          end else begin
            refill_q <= 1'b1;
            state    <= S_REFILL_NXT;
          end
        end
        S_REFILL_CUR, S_REFILL_NXT: begin
          if (flush_i) begin
            pend_flush <= 1'b1;
          end
          if (refill_done_i) begin
            refill_q   <= 1'b0;
            pend_flush <= 1'b0;
            if (pend_flush || flush_i) begin
              gnt_q <= 1'b1;
              state <= S_IDLE;
            end else begin
              rd_q  <= 1'b1;
              state <= (state == S_REFILL_CUR) ? S_LOOKUP : S_LOOKUP_NXT;
            end
          end
        end
        S_RESP: begin
          if (flush_i || core_ready_i) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            rvc_q   <= 1'b0;
            gnt_q   <= 1'b1;
            state   <= S_IDLE;
          end
        end
        default: begin
          rd_q     <= 1'b0;
          refill_q <= 1'b0;
          valid_q  <= 1'b0;
          gnt_q    <= 1'b1;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cache_instr_aligner.sv
// ---------------------------------------------------------------------------
// tb_cache_instr_aligner
//   Directed self-checking bench for cache_instr_aligner (BLOCK_SIZE=128).
//   Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_cache_instr_aligner;

  logic         clk = 1'b0;
  logic         rst_ni = 1'b0;
  logic         flush_i = 1'b0;
  logic         core_req_i = 1'b0;
  logic [31:0]  core_pc_i = '0;
  logic         core_gnt_o;
  logic         core_valid_o;
  logic         core_ready_i = 1'b0;
  logic [31:0]  core_instr_o;
  logic         core_rvc_o;
  logic         cache_rd_o;
  logic [31:0]  cache_addr_o;
  logic         cache_hit_i;
  logic [127:0] cache_block_i;
  logic         refill_req_o;
  logic [31:0]  refill_addr_o;
  logic         refill_done_i = 1'b0;

  int checks = 0;
  int fails  = 0;

  // Two-slot cache model
  logic [31:0]  la0 = 32'h100, la1 = 32'h110;
  logic [127:0] ld0 = '0, ld1 = '0;
  logic         lv0 = 1'b0, lv1 = 1'b0;

  int rd_cnt = 0;
  int valid_cnt = 0;
  logic [31:0] last_rd_addr = '0;

  assign cache_hit_i   = cache_rd_o && ((lv0 && cache_addr_o == la0) || (lv1 && cache_addr_o == la1));
  assign cache_block_i = (cache_addr_o == la0) ? ld0 : (cache_addr_o == la1) ? ld1 : '0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cache_rd_o) rd_cnt <= rd_cnt + 1;
    if (core_valid_o) valid_cnt <= valid_cnt + 1;
  end

  always @(negedge clk) begin
    if (cache_rd_o) last_rd_addr <= cache_addr_o;
  end

  cache_instr_aligner #(.BLOCK_SIZE(128), .ADDR_W(32)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i),
    .core_req_i(core_req_i), .core_pc_i(core_pc_i), .core_gnt_o(core_gnt_o),
    .core_valid_o(core_valid_o), .core_ready_i(core_ready_i),
    .core_instr_o(core_instr_o), .core_rvc_o(core_rvc_o),
    .cache_rd_o(cache_rd_o), .cache_addr_o(cache_addr_o),
    .cache_hit_i(cache_hit_i), .cache_block_i(cache_block_i),
    .refill_req_o(refill_req_o), .refill_addr_o(refill_addr_o),
    .refill_done_i(refill_done_i)
  );

  // Waits (bounded) for grant at a negedge, presents a request for one edge.
  task automatic issue(input logic [31:0] pc);
    int w = 0;
    while (core_gnt_o !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (w >= 20) begin
      fails++;
      $display("FAIL issue_grant_timeout: gnt=%b required 1", core_gnt_o);
    end
    core_req_i = 1'b1;
    core_pc_i  = pc;
    @(posedge clk);
    #1 core_req_i = 1'b0;
  endtask

  // Counts grant-edge-relative cycles until valid is seen (bounded).
  task automatic wait_valid(output int lat);
    lat = 1;
    @(negedge clk);
    while (core_valid_o !== 1'b1 && lat < 50) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic wait_refill(output int n);
    n = 0;
    while (refill_req_o !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic pulse_done();
    @(posedge clk);
    #1 refill_done_i = 1'b1;
    @(posedge clk);
    #1 refill_done_i = 1'b0;
  endtask

  task automatic finish_resp();
    @(negedge clk);
    core_ready_i = 1'b1;
    @(posedge clk);
    #1 core_ready_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({core_gnt_o, core_valid_o, cache_rd_o, refill_req_o, core_rvc_o} !== 5'b0 ||
        core_instr_o !== 32'h0 || cache_addr_o !== 32'h0 || refill_addr_o !== 32'h0) begin
      fails++;
      $display("FAIL reset_outputs: gnt=%b valid=%b rd=%b refill=%b instr=%h required all 0",
               core_gnt_o, core_valid_o, cache_rd_o, refill_req_o, core_instr_o);
    end
    @(posedge clk);
    #1 rst_ni = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (core_gnt_o !== 1'b1) begin
      fails++;
      $display("FAIL reset_idle_grant: gnt=%b required 1", core_gnt_o);
    end
  endtask

  task automatic test_rvc_hit();
    int lat, rd0;
    rd0 = rd_cnt;
    issue(32'h104);
    wait_valid(lat);
    checks++;
    if (lat !== 2) begin fails++; $display("FAIL rvc_latency: got %0d required 2", lat); end
    checks++;
    if (core_instr_o !== 32'h00004501 || core_rvc_o !== 1'b1) begin
      fails++;
      $display("FAIL rvc_instr: got %h rvc=%b required 00004501 rvc=1", core_instr_o, core_rvc_o);
    end
    checks++;
    if (rd_cnt - rd0 !== 1) begin fails++; $display("FAIL rvc_rd_cycles: got %0d required 1", rd_cnt - rd0); end
    finish_resp();
    checks++;
    if (core_valid_o !== 1'b0 || core_gnt_o !== 1'b1) begin
      fails++;
      $display("FAIL rvc_release: valid=%b gnt=%b required 0/1", core_valid_o, core_gnt_o);
    end
  endtask

  task automatic test_rv32_inline();
    int lat;
    issue(32'h108);
    wait_valid(lat);
    checks++;
    if (lat !== 2 || core_instr_o !== 32'h00100513 || core_rvc_o !== 1'b0) begin
      fails++;
      $display("FAIL rv32_inline: lat=%0d instr=%h rvc=%b required 2/00100513/0", lat, core_instr_o, core_rvc_o);
    end
    finish_resp();
  endtask

  task automatic test_straddle_hit();
    int lat;
    issue(32'h10E);
    wait_valid(lat);
    checks++;
    if (last_rd_addr !== 32'h110) begin fails++; $display("FAIL straddle_addr: got %h required 00000110", last_rd_addr); end
    checks++;
    if (lat !== 3 || core_instr_o !== 32'h00500093 || core_rvc_o !== 1'b0) begin
      fails++;
      $display("FAIL straddle_hit: lat=%0d instr=%h rvc=%b required 3/00500093/0", lat, core_instr_o, core_rvc_o);
    end
    finish_resp();
  endtask

  task automatic test_straddle_miss();
    int n, lat;
    lv1 = 1'b0;
    issue(32'h10E);
    wait_refill(n);
    checks++;
    if (refill_req_o !== 1'b1 || refill_addr_o !== 32'h110) begin
      fails++;
      $display("FAIL nxt_refill_addr: req=%b addr=%h required 1/00000110", refill_req_o, refill_addr_o);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (refill_req_o !== 1'b1 || refill_addr_o !== 32'h110) begin
        fails++;
        $display("FAIL nxt_refill_hold: req=%b addr=%h required 1/00000110", refill_req_o, refill_addr_o);
      end
    end
    lv1 = 1'b1;
    pulse_done();
    wait_valid(lat);
    checks++;
    if (core_valid_o !== 1'b1 || core_instr_o !== 32'h00500093 || refill_req_o !== 1'b0) begin
      fails++;
      $display("FAIL nxt_refill_result: valid=%b instr=%h refill=%b required 1/00500093/0",
               core_valid_o, core_instr_o, refill_req_o);
    end
    finish_resp();
  endtask

  task automatic test_wrap();
    int lat;
    logic [127:0] d0, d1;
    d0 = '0; d1 = '0;
    d0[7*16 +: 16] = 16'h0537;
    d1[15:0] = 16'h1234;
    la0 = 32'hFFFF_FFF0; ld0 = d0; lv0 = 1'b1;
    la1 = 32'h0000_0000; ld1 = d1; lv1 = 1'b1;
    issue(32'hFFFF_FFFE);
    wait_valid(lat);
    checks++;
    if (last_rd_addr !== 32'h0 || lat !== 3 || core_instr_o !== 32'h12340537) begin
      fails++;
      $display("FAIL wrap: addr=%h lat=%0d instr=%h required 00000000/3/12340537", last_rd_addr, lat, core_instr_o);
    end
    finish_resp();
  endtask

  task automatic test_flush();
    int n, v0;
    // Flush in IDLE blocks the grant and beats a request.
    @(negedge clk);
    flush_i = 1'b1; core_req_i = 1'b1; core_pc_i = 32'h104;
    #1;
    checks++;
    if (core_gnt_o !== 1'b0) begin fails++; $display("FAIL flush_idle_gnt: got %b required 0", core_gnt_o); end
    @(posedge clk);
    #1 flush_i = 1'b0; core_req_i = 1'b0;
    @(negedge clk);
    checks++;
    if (cache_rd_o !== 1'b0 || core_gnt_o !== 1'b1) begin
      fails++;
      $display("FAIL flush_beats_req: rd=%b gnt=%b required 0/1", cache_rd_o, core_gnt_o);
    end
    // Flush during LOOKUP abandons the request.
    v0 = valid_cnt;
    issue(32'h104);
    flush_i = 1'b1;
    @(posedge clk);
    #1 flush_i = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (valid_cnt !== v0 || core_gnt_o !== 1'b1) begin
      fails++;
      $display("FAIL flush_lookup: valid_cycles=%0d gnt=%b required 0/1", valid_cnt - v0, core_gnt_o);
    end
    // Flush during REFILL_CUR keeps the refill going, then drops to IDLE.
    issue(32'h200);
    wait_refill(n);
    checks++;
    if (refill_req_o !== 1'b1 || refill_addr_o !== 32'h200) begin
      fails++;
      $display("FAIL cur_refill_addr: req=%b addr=%h required 1/00000200", refill_req_o, refill_addr_o);
    end
    @(posedge clk);
    #1 flush_i = 1'b1;
    @(posedge clk);
    #1 flush_i = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (refill_req_o !== 1'b1) begin fails++; $display("FAIL flush_refill_hold: req=%b required 1", refill_req_o); end
    end
    la1 = 32'h200; lv1 = 1'b1;
    pulse_done();
    repeat (4) @(negedge clk);
    checks++;
    if (refill_req_o !== 1'b0 || core_gnt_o !== 1'b1 || valid_cnt !== v0) begin
      fails++;
      $display("FAIL flush_refill_end: refill=%b gnt=%b valid_cycles=%0d required 0/1/0",
               refill_req_o, core_gnt_o, valid_cnt - v0);
    end
    lv1 = 1'b0;
  endtask

  task automatic test_resp_stall();
    int lat;
    issue(32'h104);
    wait_valid(lat);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (core_valid_o !== 1'b1 || core_instr_o !== 32'h00004501 || core_rvc_o !== 1'b1) begin
        fails++;
        $display("FAIL resp_stall: valid=%b instr=%h rvc=%b required 1/00004501/1", core_valid_o, core_instr_o, core_rvc_o);
      end
    end
    finish_resp();
  endtask

  task automatic test_reset_mid_refill();
    int n;
    issue(32'h200);
    wait_refill(n);
    checks++;
    if (refill_req_o !== 1'b1) begin fails++; $display("FAIL rst_pre_refill: req=%b required 1", refill_req_o); end
    #2 rst_ni = 1'b0;
    #1;
    checks++;
    if ({core_gnt_o, core_valid_o, cache_rd_o, refill_req_o} !== 4'b0 || refill_addr_o !== 32'h0) begin
      fails++;
      $display("FAIL rst_mid_refill: gnt=%b valid=%b rd=%b refill=%b addr=%h required all 0",
               core_gnt_o, core_valid_o, cache_rd_o, refill_req_o, refill_addr_o);
    end
    @(posedge clk);
    #1 rst_ni = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (core_gnt_o !== 1'b1 || refill_req_o !== 1'b0) begin
      fails++;
      $display("FAIL rst_recover: gnt=%b refill=%b required 1/0", core_gnt_o, refill_req_o);
    end
  endtask

  initial begin
    ld0[2*16 +: 16] = 16'h4501;
    ld0[4*16 +: 16] = 16'h0513;
    ld0[5*16 +: 16] = 16'h0010;
    ld0[7*16 +: 16] = 16'h0093;
    ld1[15:0]       = 16'h0050;
    lv0 = 1'b1; lv1 = 1'b1;

    test_reset();
    test_rvc_hit();
    test_rv32_inline();
    test_straddle_hit();
    test_straddle_miss();
    test_resp_stall();
    test_flush();
    test_reset_mid_refill();
    test_wrap();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

`default_nettype wire
